memory_control: RTL

Bus arbiter and RAM sequencer between the per-CPU `caches` blocks and the single-ported system RAM. It collects instruction and data read/write requests from `CPUS` cores and grants one request at a time to RAM. It drives the RAM handshake and returns per-requester `iwait`/`dwait` and load data. It is the downstream consumer of every core's `ccif` requests.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 41 ++++
 rtl/memory_control.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_types_pkg : shared RAM status / word types and memory_control states |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Prefixed so the names do not collide with the ramstate_t literals
  typedef enum logic [0:0] {
    MC_IDLE   = 1'b0,
    MC_ACCESS = 1'b1
  } mc_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : combinational round-robin pick of the next RAM requester   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int CPUS = 2,
  parameter int IDW  = 1
) (
  input  logic [CPUS-1:0] iREN,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  logic [IDW-1:0]  last,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_data,
  output logic            gnt_write
);

  logic [IDW-1:0] w_idx;

  // Scan starts one past the previous owner and wraps back around to it
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    gnt_data  = 1'b0;
    gnt_write = 1'b0;
    w_idx     = '0;
    for (int k = 1; k <= CPUS; k++) begin
      w_idx = IDW'((int'(last) + k) % CPUS);
      if (!gnt_valid && (iREN[w_idx] || dREN[w_idx] || dWEN[w_idx])) begin
        gnt_valid = 1'b1;
        gnt_id    = w_idx;
        gnt_data  = dREN[w_idx] || dWEN[w_idx];
        gnt_write = dWEN[w_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_control : arbitrates core I/D requests onto the single RAM port   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [CPUS-1:0]             iREN,
  input  logic [CPUS-1:0]             dREN,
  input  logic [CPUS-1:0]             dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0] iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0] daddr,
  input  logic [CPUS-1:0][WORD_W-1:0] dstore,
  output logic [CPUS-1:0]             iwait,
  output logic [CPUS-1:0]             dwait,
  output logic [CPUS-1:0][WORD_W-1:0] iload,
  output logic [CPUS-1:0][WORD_W-1:0] dload,
  output logic                        ramREN,
  output logic                        ramWEN,
  output logic [WORD_W-1:0]           ramaddr,
  output logic [WORD_W-1:0]           ramstore,
  input  logic [WORD_W-1:0]           ramload,
  input  logic [1:0]                  ramstate
);

  localparam int IDW = (CPUS > 1) ? $clog2(CPUS) : 1;

  mc_state_t         r_state, w_state_nxt;
  logic [IDW-1:0]    r_last, w_last_nxt;
  logic [IDW-1:0]    r_owner;
  logic              r_is_d, r_write;
  logic [WORD_W-1:0] r_addr, r_store;

  logic              w_gnt_valid, w_gnt_data, w_gnt_write, w_grant, w_held;
  logic [IDW-1:0]    w_gnt_id;
  ramstate_t         w_rs;

  assign w_rs = ramstate_t'(ramstate);

  mem_arbiter #(
    .CPUS (CPUS),
    .IDW  (IDW)
  ) u_arb (
    .iREN      (iREN),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id),
    .gnt_data  (w_gnt_data),
    .gnt_write (w_gnt_write)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= MC_IDLE;
      r_last  <= IDW'(CPUS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Address and store data are captured only at grant time
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_owner <= '0;
      r_is_d  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else if (w_grant) begin
      r_owner <= w_gnt_id;
      r_is_d  <= w_gnt_data;
      r_write <= w_gnt_write;
      r_addr  <= w_gnt_data ? daddr[w_gnt_id] : iaddr[w_gnt_id];
      r_store <= dstore[w_gnt_id];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_grant     = 1'b0;
    w_held      = r_is_d ? (r_write ? dWEN[r_owner] : dREN[r_owner]) : iREN[r_owner];
    iwait       = '1;
    dwait       = '1;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    case (r_state)
      MC_IDLE: begin
        if (w_gnt_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = MC_ACCESS;
        end
      end
      MC_ACCESS: begin
        ramREN = !r_write;
        ramWEN = r_write;
        // A withdrawn request aborts silently, even if RAM completes now
        if (!w_held) begin
          w_state_nxt = MC_IDLE;
        end else if (w_rs == ACCESS) begin
          w_state_nxt = MC_IDLE;
          w_last_nxt  = r_owner;
          if (r_is_d) dwait[r_owner] = 1'b0;
          else        iwait[r_owner] = 1'b0;
        end else if (w_rs == ERROR) begin
          w_state_nxt = MC_IDLE;
        end
      end
      default: w_state_nxt = MC_IDLE;
    endcase
  end

  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign iload    = {CPUS{ramload}};
  assign dload    = {CPUS{ramload}};

endmodule
`default_nettype wire
